// File: rtl/u_lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } lsu_st_e;

  // Lane masks that form a naturally aligned byte, half-word or word access.
  localparam logic [3:0] BE_LEGAL [0:6] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000,
    4'b0011, 4'b1100, 4'b1111
  };

  // Expand 4 byte enables into a 32-bit data mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  // True when the mask is one of the aligned access shapes.
  function automatic logic be_legal(input logic [3:0] be);
    logic ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < 7; i++) begin
      if (be == BE_LEGAL[i]) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/u_lsu_if.sv
// Data-memory bus: request/grant handshake followed by an rvalid response.
interface u_lsu_if #(
  parameter int unsigned AW = 32
);
  logic          req;
  logic          gnt;
  logic          we;
  logic [3:0]    be;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          rvalid;
  logic [31:0]   rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/u_lsu.sv
// Load/store unit: turns one registered LSU request into a single data-memory
// bus transaction, with one transaction outstanding and a timeout abort.
module u_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TMO_CYC = 255,
  parameter int unsigned AW      = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [31:0]   lsu_a,
  input  logic [3:0]    lsu_we,
  input  logic [31:0]   lsu_wd,
  input  logic [3:0]    lsu_re,
  output logic          lsu_vld,
  output logic [31:0]   lsu_rd,
  output logic          lsu_busy,
  output logic          lsu_err,
  u_lsu_if.master       dmem
);

  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

  lsu_st_e       st_q, st_d;
  logic [15:0]   cnt_q;
  logic          we_any, re_any, req_any, req_legal;
  logic          accept, done, tmo, err_d;
  logic          we_q;
  logic [3:0]    be_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;

  assign we_any    = |lsu_we;
  assign re_any    = |lsu_re;
  assign req_any   = we_any | re_any;
  assign req_legal = !(we_any && re_any) && be_legal(we_any ? lsu_we : lsu_re);

  assign dmem.req   = (st_q == REQ);
  assign dmem.we    = we_q;
  assign dmem.be    = be_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;
  assign lsu_busy   = (st_q != IDLE);

  // Next-state, completion/timeout detection and error source decode.
  always_comb begin
    st_d   = st_q;
    accept = 1'b0;
    done   = 1'b0;
    tmo    = 1'b0;
    case (st_q)
      IDLE: begin
        if (req_any && req_legal) begin
          st_d   = REQ;
          accept = 1'b1;
        end
      end
      REQ: begin
        if (dmem.gnt) begin
          st_d = RESP;
        end else if (cnt_q == TMO_LAST) begin
          st_d = IDLE;
          tmo  = 1'b1;
        end
      end
      RESP: begin
        // A response arriving on the timeout cycle still completes normally.
        if (dmem.rvalid) begin
          st_d = IDLE;
          done = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          st_d = IDLE;
          tmo  = 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
    err_d = tmo || (req_any && ((st_q != IDLE) || !req_legal));
  end

  // State, timeout counter, captured bus fields and registered result pulses.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      lsu_vld <= 1'b0;
      lsu_rd  <= '0;
      lsu_err <= 1'b0;
    end else begin
      st_q    <= st_d;
      lsu_vld <= done || tmo;
      lsu_err <= err_d;
      lsu_rd  <= (done && !we_q) ? (dmem.rdata & lane_mask(be_q)) : '0;
      if (accept) begin
        cnt_q   <= '0;
        we_q    <= we_any;
        be_q    <= we_any ? lsu_we : lsu_re;
        addr_q  <= {lsu_a[AW-1:2], 2'b00};
        wdata_q <= lsu_wd;
      end else if (st_q != IDLE && cnt_q != TMO_LAST) begin
        // Saturating at the abort value keeps the limit spanning REQ and RESP.
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_u_lsu.sv
// Directed bench for u_lsu: vector table of single transactions plus
// hand-written timeout, collision and reset sequences.
module tb_u_lsu;

  logic        clk;
  logic        rstn;
  logic [31:0] lsu_a;
  logic [3:0]  lsu_we;
  logic [31:0] lsu_wd;
  logic [3:0]  lsu_re;
  logic        lsu_vld;
  logic [31:0] lsu_rd;
  logic        lsu_busy;
  logic        lsu_err;

  u_lsu_if #(.AW(32)) dmem_bus ();

  u_lsu #(.TMO_CYC(8), .AW(32)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .lsu_a    (lsu_a),
    .lsu_we   (lsu_we),
    .lsu_wd   (lsu_wd),
    .lsu_re   (lsu_re),
    .lsu_vld  (lsu_vld),
    .lsu_rd   (lsu_rd),
    .lsu_busy (lsu_busy),
    .lsu_err  (lsu_err),
    .dmem     (dmem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  we;
    logic [31:0] wd;
    logic [3:0]  re;
    int unsigned gnt_dly;
    logic [31:0] rdata;
    logic        exp_err;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic        exp_we;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [8];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    lsu_a  = '0;
    lsu_we = '0;
    lsu_wd = '0;
    lsu_re = '0;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [3:0] we,
                           input logic [31:0] wd, input logic [3:0] re);
    lsu_a  = a;
    lsu_we = we;
    lsu_wd = wd;
    lsu_re = re;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int unsigned req_cyc;
    @(negedge clk);
    drive_req(v.a, v.we, v.wd, v.re);
    @(negedge clk);
    idle_inputs();
    if (v.exp_err) begin
      chk($sformatf("v%0d_err", idx), 32'(lsu_err), 32'd1);
      chk($sformatf("v%0d_noreq", idx), 32'(dmem_bus.req), 32'd0);
      chk($sformatf("v%0d_idle", idx), 32'(lsu_busy), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_err_pulse", idx), 32'(lsu_err), 32'd0);
      chk($sformatf("v%0d_noreq2", idx), 32'(dmem_bus.req), 32'd0);
      return;
    end
    chk($sformatf("v%0d_busy", idx), 32'(lsu_busy), 32'd1);
    chk($sformatf("v%0d_addr", idx), dmem_bus.addr, v.exp_addr);
    chk($sformatf("v%0d_be", idx), 32'(dmem_bus.be), 32'(v.exp_be));
    chk($sformatf("v%0d_we", idx), 32'(dmem_bus.we), 32'(v.exp_we));
    chk($sformatf("v%0d_wdata", idx), dmem_bus.wdata, v.wd);
    req_cyc = 0;
    for (int unsigned d = 0; d < v.gnt_dly; d++) begin
      if (dmem_bus.req) req_cyc++;
      @(negedge clk);
    end
    if (dmem_bus.req) req_cyc++;
    dmem_bus.gnt = 1'b1;
    @(negedge clk);
    dmem_bus.gnt = 1'b0;
    chk($sformatf("v%0d_req_cycles", idx), req_cyc, v.gnt_dly + 1);
    chk($sformatf("v%0d_req_drop", idx), 32'(dmem_bus.req), 32'd0);
    chk($sformatf("v%0d_busy_resp", idx), 32'(lsu_busy), 32'd1);
    chk($sformatf("v%0d_addr_stable", idx), dmem_bus.addr, v.exp_addr);
    dmem_bus.rvalid = 1'b1;
    dmem_bus.rdata  = v.rdata;
    @(negedge clk);
    dmem_bus.rvalid = 1'b0;
    dmem_bus.rdata  = '0;
    chk($sformatf("v%0d_vld", idx), 32'(lsu_vld), 32'd1);
    chk($sformatf("v%0d_rd", idx), lsu_rd, v.exp_rd);
    chk($sformatf("v%0d_busy_done", idx), 32'(lsu_busy), 32'd0);
    chk($sformatf("v%0d_no_err", idx), 32'(lsu_err), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_vld_pulse", idx), 32'(lsu_vld), 32'd0);
  endtask

  initial begin
    int unsigned n;

    vecs[0] = '{32'h0000_0100, 4'b0000, 32'h0,         4'b1111, 0, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 4'b1111, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_0203, 4'b1000, 32'hAB00_0000, 4'b0000, 3, 32'hFFFF_FFFF, 1'b0, 32'h0000_0200, 4'b1000, 1'b1, 32'h0};
    vecs[2] = '{32'h0000_0302, 4'b0000, 32'h0,         4'b1100, 0, 32'h1234_5678, 1'b0, 32'h0000_0300, 4'b1100, 1'b0, 32'h1234_0000};
    vecs[3] = '{32'h0000_0400, 4'b0101, 32'h5555_5555, 4'b0000, 0, 32'h0,         1'b1, 32'h0,         4'b0000, 1'b0, 32'h0};
    vecs[4] = '{32'h0000_0404, 4'b1111, 32'h1111_1111, 4'b0001, 0, 32'h0,         1'b1, 32'h0,         4'b0000, 1'b0, 32'h0};
    vecs[5] = '{32'h0000_0011, 4'b0000, 32'h0,         4'b0010, 2, 32'hA1B2_C3D4, 1'b0, 32'h0000_0010, 4'b0010, 1'b0, 32'h0000_C300};
    vecs[6] = '{32'h0000_0020, 4'b0011, 32'h0000_BEEF, 4'b0000, 1, 32'h7777_7777, 1'b0, 32'h0000_0020, 4'b0011, 1'b1, 32'h0};
    vecs[7] = '{32'h0000_0030, 4'b0000, 32'h0,         4'b0110, 0, 32'h0,         1'b1, 32'h0,         4'b0000, 1'b0, 32'h0};

    rstn = 1'b0;
    idle_inputs();
    dmem_bus.gnt    = 1'b0;
    dmem_bus.rvalid = 1'b0;
    dmem_bus.rdata  = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    chk("rst_vld",   32'(lsu_vld),        32'd0);
    chk("rst_rd",    lsu_rd,              32'd0);
    chk("rst_busy",  32'(lsu_busy),       32'd0);
    chk("rst_err",   32'(lsu_err),        32'd0);
    chk("rst_req",   32'(dmem_bus.req),   32'd0);
    chk("rst_we",    32'(dmem_bus.we),    32'd0);
    chk("rst_be",    32'(dmem_bus.be),    32'd0);
    chk("rst_addr",  dmem_bus.addr,       32'd0);
    chk("rst_wdata", dmem_bus.wdata,      32'd0);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Timeout: grant never comes, request held for 8 cycles then aborted.
    @(negedge clk);
    drive_req(32'h0000_0040, 4'b0000, 32'h0, 4'b1111);
    @(negedge clk);
    idle_inputs();
    n = 0;
    while (dmem_bus.req && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_req_cycles", n, 32'd8);
    chk("tmo_vld", 32'(lsu_vld), 32'd1);
    chk("tmo_err", 32'(lsu_err), 32'd1);
    chk("tmo_rd",  lsu_rd,       32'd0);
    chk("tmo_idle", 32'(lsu_busy), 32'd0);
    run_vec(100, vecs[0]);

    // Collision: second request during RESP is rejected, first completes.
    @(negedge clk);
    drive_req(32'h0000_0500, 4'b0000, 32'h0, 4'b1111);
    @(negedge clk);
    idle_inputs();
    dmem_bus.gnt = 1'b1;
    @(negedge clk);
    dmem_bus.gnt = 1'b0;
    drive_req(32'h0000_0600, 4'b1111, 32'h9999_9999, 4'b0000);
    @(negedge clk);
    idle_inputs();
    chk("col_err",  32'(lsu_err),      32'd1);
    chk("col_busy", 32'(lsu_busy),     32'd1);
    chk("col_noreq", 32'(dmem_bus.req), 32'd0);
    chk("col_addr", dmem_bus.addr,     32'h0000_0500);
    dmem_bus.rvalid = 1'b1;
    dmem_bus.rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    dmem_bus.rvalid = 1'b0;
    dmem_bus.rdata  = '0;
    chk("col_vld", 32'(lsu_vld), 32'd1);
    chk("col_rd",  lsu_rd,       32'hCAFE_F00D);
    chk("col_err_clr", 32'(lsu_err), 32'd0);

    // Reset during REQ abandons the transaction silently.
    @(negedge clk);
    drive_req(32'h0000_0700, 4'b0001, 32'h0000_0042, 4'b0000);
    @(negedge clk);
    idle_inputs();
    chk("rreq_req", 32'(dmem_bus.req), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    chk("rreq_req0",  32'(dmem_bus.req), 32'd0);
    chk("rreq_busy0", 32'(lsu_busy),     32'd0);
    chk("rreq_be0",   32'(dmem_bus.be),  32'd0);
    chk("rreq_addr0", dmem_bus.addr,     32'd0);
    chk("rreq_wd0",   dmem_bus.wdata,    32'd0);
    chk("rreq_we0",   32'(dmem_bus.we),  32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rreq_vld", 32'(lsu_vld),  32'd0);
    chk("rreq_err", 32'(lsu_err),  32'd0);
    chk("rreq_idle", 32'(lsu_busy), 32'd0);
    run_vec(200, vecs[2]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/u_lsu.md
Name: u_lsu

Overview:
- Load/store unit. It is the responder to the execute stage's registered LSU request (`lsu_a/we/wd/re`) and returns `lsu_vld/lsu_rd`.
- It converts each single-cycle request into one transaction on the data-memory bus (req/gnt/rvalid), then reports completion.
- Exactly one transaction is outstanding at a time. `lsu_busy` feeds the hazard unit so the pipeline stalls while the LSU is occupied.

Parameters:
- TMO_CYC, 255: cycles allowed from transaction start to rvalid before abort; range 1..65535.
- AW, 32: data-memory address width; low AW bits of `lsu_a` are used.

Ports:
- clk  in  1  clock, all logic on posedge.
- rstn  in  1  reset; synchronous, active-low.
- lsu_a  in  32  byte address; word address = `lsu_a[AW-1:2]`.
- lsu_we  in  4  byte-lane write enables; non-zero = store request.
- lsu_wd  in  32  lane-aligned store data.
- lsu_re  in  4  byte-lane read enables; non-zero = load request.
- lsu_vld  out  1  one-cycle completion pulse, load or store.
- lsu_rd  out  32  load data, lane-masked; valid only with `lsu_vld`.
- lsu_busy  out  1  high in every non-IDLE state.
- lsu_err  out  1  one-cycle pulse: illegal request, request while busy, or timeout.
- dmem_req  out  1  bus request; held until gnt.
- dmem_gnt  in  1  bus grant.
- dmem_we  out  1  1 = write.
- dmem_be  out  4  byte enables.
- dmem_addr  out  AW  word-aligned address (`[1:0]` = 0).
- dmem_wdata  out  32  write data.
- dmem_rvalid  in  1  response/ack; for writes it is an ack only.
- dmem_rdata  in  32  read data.

Behaviour:
- Reset (`rstn`=0 at posedge):
  - State = IDLE, timeout counter = 0.
  - All outputs 0: `lsu_vld`, `lsu_rd`, `lsu_busy`, `lsu_err`, `dmem_req`, `dmem_we`, `dmem_be`, `dmem_addr`, `dmem_wdata`.
  - Reset mid-transaction abandons it; no `lsu_vld`/`lsu_err` is produced for it.
- Request detect, IDLE only: `we_any = |lsu_we`, `re_any = |lsu_re`.
- Legal lane masks: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- Illegal request: `we_any & re_any`, or an illegal mask. Result: request dropped, `lsu_err` pulses next cycle, state stays IDLE.
- Request while not IDLE: dropped, `lsu_err` pulses next cycle, current transaction unaffected.
- FSM states: IDLE, REQ, RESP.
  - IDLE -> REQ on a legal request at cycle N. At that edge, capture `dmem_we=we_any`, `dmem_be=we_any?lsu_we:lsu_re`, `dmem_addr={lsu_a[AW-1:2],2'b00}`, `dmem_wdata=lsu_wd`; counter = 0.
  - REQ: `dmem_req`=1 and all `dmem_*` outputs stable. When `dmem_gnt`=1, go to RESP and deassert `dmem_req` at the same edge.
  - RESP: wait for `dmem_rvalid`. On rvalid, at that edge: state -> IDLE; `lsu_vld`=1 for one cycle; `lsu_rd = dmem_we ? 0 : dmem_rdata & lane_mask(dmem_be)`.
  - `dmem_rvalid` seen in REQ or IDLE is ignored.
- Best case: request at N, gnt in N+1, rvalid in N+2. Then `lsu_vld` is high in N+3 and a new request is accepted in N+3.
- `lsu_busy` = (state != IDLE), registered with the state; it is high from N+1.
- Timeout:
  - The counter increments every cycle in REQ or RESP and saturates.
  - When counter == TMO_CYC-1 with no gnt (REQ) or no rvalid (RESP): state -> IDLE, `dmem_req`=0, and in the following cycle `lsu_vld`=1, `lsu_rd`=0, `lsu_err`=1 together.
  - Completion in the same cycle as timeout: completion wins, no error.
- `lsu_vld` and `lsu_err` are registered pulses, never high for two consecutive cycles for the same event.

Decomposition:
- Package `lsu_pkg`:
  - `lsu_st_e` enum {IDLE, REQ, RESP}.
  - Constant `BE_LEGAL` list.
  - Function `lane_mask(be)` -> 32-bit mask.
  - Function `be_legal(be)`.
- No sub-module required.
- Optional sub-module `u_lsu_tmo`: saturating counter with clear/enable/hit.

Test Plan:
- Word load: `lsu_a`=0x100, `lsu_re`=1111; gnt at +1, rvalid at +2 with rdata 0xDEADBEEF -> `dmem_addr`=0x100, `dmem_we`=0, `dmem_be`=1111; `lsu_vld` at N+3, `lsu_rd`=0xDEADBEEF; busy N+1..N+2.
- Byte store: `lsu_a`=0x203, `lsu_we`=1000, `lsu_wd`=0xAB000000; gnt delayed 3 cycles -> `dmem_req` held 4 cycles, `dmem_addr`=0x200, `dmem_be`=1000, `dmem_we`=1; `lsu_vld` with `lsu_rd`=0 after rvalid.
- Half load upper lanes: `lsu_re`=1100, rdata 0x12345678 -> `lsu_rd`=0x12340000.
- Illegal requests: `lsu_we`=0101; then `lsu_we`=1111 with `lsu_re`=0001 -> each gives an `lsu_err` pulse, no `dmem_req`, stays IDLE.
- Timeout: TMO_CYC=8, gnt never asserted -> `dmem_req` drops after 8 cycles; next cycle `lsu_vld`=`lsu_err`=1, `lsu_rd`=0; next request accepted.
- Busy collision and reset: second request during RESP -> `lsu_err` pulse, first completes normally. `rstn`=0 during REQ -> next cycle all outputs 0, no `lsu_vld`.
